// File: rtl/ace_mem_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package ace_mem_pkg;

  localparam int unsigned ADDR_W              = 32;
  localparam int unsigned DATA_W              = 32;
  localparam int unsigned TIMEOUT_CYCLES_DFLT = 256;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; ptr is the port granted last, ties go to the other one.
module rr_arb2
  import ace_mem_pkg::*;
(
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] grant
);

  always_comb begin
    grant    = '0;
    grant[0] = req[0] & (~req[1] | ptr);
    grant[1] = req[1] & (~req[0] | ~ptr);
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of an SRAM IO controller, one transaction at a time.
// Optional ack watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter
  import ace_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DFLT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_read,
  input  logic              p0_write,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_write_data,
  output logic              p0_ack,
  output logic [DATA_W-1:0] p0_read_data,
  output logic              p0_err,
  input  logic              p1_read,
  input  logic              p1_write,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_write_data,
  output logic              p1_ack,
  output logic [DATA_W-1:0] p1_read_data,
  output logic              p1_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_read_data
);

  arb_state_t        state;
  logic              last_grant;
  logic              win;
  logic              cmd_write;
  logic [1:0]        req;
  logic [1:0]        grant;
  logic              sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  assign req = {p1_read | p1_write, p0_read | p0_write};

  rr_arb2 u_rr_arb2 (
    .req   (req),
    .ptr   (last_grant),
    .grant (grant)
  );

  always_comb begin
    sel_write = p0_write;
    sel_addr  = p0_addr;
    sel_wdata = p0_write_data;
    if (grant[1]) begin
      sel_write = p1_write;
      sel_addr  = p1_addr;
      sel_wdata = p1_write_data;
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic             p0_err_q;
  logic             p1_err_q;
  logic [CNT_W-1:0] to_cnt;
  assign p0_err = p0_err_q;
  assign p1_err = p1_err_q;
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT_CYCLES != 0);
  assign p0_err = 1'b0;
  assign p1_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= ST_IDLE;
      last_grant     <= 1'b1;
      win            <= 1'b0;
      cmd_write      <= 1'b0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_addr       <= '0;
      mem_write_data <= '0;
      p0_ack         <= 1'b0;
      p1_ack         <= 1'b0;
      p0_read_data   <= '0;
      p1_read_data   <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      p0_err_q       <= 1'b0;
      p1_err_q       <= 1'b0;
      to_cnt         <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (|grant) begin
            win            <= grant[1];
            last_grant     <= grant[1];
            cmd_write      <= sel_write;
            mem_write      <= sel_write;
            mem_read       <= ~sel_write;
            mem_addr       <= sel_addr;
            mem_write_data <= sel_wdata;
            state          <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
          to_cnt    <= '0;
`endif
          state     <= ST_WAIT;
        end
        ST_WAIT: begin
          // Address/data stay driven through the ack cycle and drop as RESP begins.
          if (mem_ack) begin
            if (win) begin
              p1_ack       <= 1'b1;
              p1_read_data <= cmd_write ? '0 : mem_read_data;
            end else begin
              p0_ack       <= 1'b1;
              p0_read_data <= cmd_write ? '0 : mem_read_data;
            end
            mem_addr       <= '0;
            mem_write_data <= '0;
            state          <= ST_RESP;
          end
`ifdef MEM_ARB_TIMEOUT_EN
          else if (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            if (win) begin
              p1_ack   <= 1'b1;
              p1_err_q <= 1'b1;
            end else begin
              p0_ack   <= 1'b1;
              p0_err_q <= 1'b1;
            end
            mem_addr       <= '0;
            mem_write_data <= '0;
            state          <= ST_RESP;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        ST_RESP: begin
          p0_ack       <= 1'b0;
          p1_ack       <= 1'b0;
          p0_read_data <= '0;
          p1_read_data <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
          p0_err_q     <= 1'b0;
          p1_err_q     <= 1'b0;
`endif
          state        <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
